// File: rtl/regfile_scoreboard.sv
// Architectural register file with a per-register pending-writer scoreboard.
// WB results are bypassed to the read ports in the same cycle they are written.
module regfile_scoreboard #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CNTW = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [4:0]    raddr1,
  input  logic [4:0]    raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          busy1,
  output logic          busy2,
  input  logic          issue_valid,
  input  logic          issue_we,
  input  logic [4:0]    issue_waddr,
  output logic          issue_full,
  input  logic          wb_valid,
  input  logic          wb_we,
  input  logic [4:0]    wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  input  logic          flush,
  output logic          sb_overflow
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [DW-1:0]   regs_q [NREG];
  logic [CNTW-1:0] cnt_q  [NREG];
  logic [CNTW-1:0] cnt_d  [NREG];
  logic            sbOverflow_q;
  logic            sbOverflow_d;
  logic [NREG-1:0] incHit;
  logic [NREG-1:0] decHit;
  logic            issueWrite;
  logic            wbWrite;

  assign issueWrite = issue_valid & issue_we;
  assign wbWrite    = wb_valid & wb_we;

  always_comb begin
    incHit = '0;
    decHit = '0;
    for (int k = 1; k < NREG; k++) begin
      incHit[k] = issueWrite && (issue_waddr == 5'(k));
      decHit[k] = wbWrite && (wb_waddr == 5'(k));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NREG; k++) regs_q[k] <= '0;
    end else if (wbWrite && (wb_waddr != 5'd0)) begin
      regs_q[wb_waddr] <= wb_wdata;
    end
  end

  // A simultaneous issue and retire on one register cancel; flush wins over both.
  always_comb begin
    sbOverflow_d = sbOverflow_q;
    for (int k = 0; k < NREG; k++) cnt_d[k] = cnt_q[k];
    cnt_d[0] = '0;
    for (int k = 1; k < NREG; k++) begin
      if (incHit[k] && !decHit[k] && (cnt_q[k] == CNT_MAX)) sbOverflow_d = 1'b1;
      if (flush) begin
        cnt_d[k] = '0;
      end else if (incHit[k] && !decHit[k]) begin
        if (cnt_q[k] != CNT_MAX) cnt_d[k] = cnt_q[k] + CNTW'(1);
      end else if (decHit[k] && !incHit[k]) begin
        if (cnt_q[k] != '0) cnt_d[k] = cnt_q[k] - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NREG; k++) cnt_q[k] <= '0;
      sbOverflow_q <= 1'b0;
    end else begin
      for (int k = 0; k < NREG; k++) cnt_q[k] <= cnt_d[k];
      sbOverflow_q <= sbOverflow_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = decHit[raddr1] ? wb_wdata : regs_q[raddr1];
    if (raddr2 != 5'd0) rdata2 = decHit[raddr2] ? wb_wdata : regs_q[raddr2];
  end

  // The last writer retiring this cycle is covered by the bypass, so it does not stall.
  assign busy1 = (raddr1 != 5'd0) && (cnt_q[raddr1] > CNTW'(decHit[raddr1]));
  assign busy2 = (raddr2 != 5'd0) && (cnt_q[raddr2] > CNTW'(decHit[raddr2]));

  assign issue_full  = (issue_waddr != 5'd0) && (cnt_q[issue_waddr] == CNT_MAX)
                       && !decHit[issue_waddr];
  assign sb_overflow = sbOverflow_q;

endmodule
